// File: rtl/approx_mult_pkg.sv
// Shared types and width helpers for the approximate multiplier engine.
package approx_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    MULT,
    DENORM,
    DONE
  } state_t;

  function automatic int out_w_f(input int in_w);
    return 2 * in_w;
  endfunction

  function automatic int sh_w_f(input int in_w);
    return $clog2(2 * in_w) + 1;
  endfunction

endpackage

// File: rtl/approx_norm_lane.sv
// One operand lane: shift left until the MSB is set, counting the shifts.
// Exposes the top TRUNC_W field, rounded half-up when APPROX_MULT_ROUND_EN is defined.
module approx_norm_lane #(
  parameter int IN_W    = 16,
  parameter int TRUNC_W = 8,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [IN_W-1:0]    data,
  output logic [TRUNC_W-1:0] norm_top,
  output logic [CNT_W-1:0]   count,
  output logic               msb_set
);

  logic [IN_W-1:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= data;
      count <= '0;
    end else if (step && !value[IN_W-1]) begin
      value <= {value[IN_W-2:0], 1'b0};
      count <= count + CNT_W'(1);
    end
  end

  assign msb_set = value[IN_W-1];

`ifdef APPROX_MULT_ROUND_EN
  if (TRUNC_W < IN_W) begin : g_round
    // Saturate instead of carrying out: an all-ones field stays all-ones.
    always_comb begin
      norm_top = value[IN_W-1 -: TRUNC_W];
      if (value[IN_W-TRUNC_W-1] && (norm_top != '1))
        norm_top = norm_top + TRUNC_W'(1);
    end
  end else begin : g_trunc
    assign norm_top = value[IN_W-1 -: TRUNC_W];
  end
`else
  assign norm_top = value[IN_W-1 -: TRUNC_W];
`endif

endmodule

// File: rtl/approx_mult_engine.sv
// Self-sequenced approximate multiplier: normalise, multiply top fields, denormalise.
// Optional round-half-up of the top fields via APPROX_MULT_ROUND_EN.
module approx_mult_engine
  import approx_mult_pkg::*;
#(
  parameter  int IN_W    = 16,
  parameter  int TRUNC_W = 8,
  localparam int OUT_W   = out_w_f(IN_W),
  localparam int SH_W    = sh_w_f(IN_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  result,
  output logic [SH_W-1:0]   shift_total
);

  state_t state, state_next;

  logic                 lane_load, lane_step;
  logic                 zero_op;
  logic [TRUNC_W-1:0]   a_top, b_top;
  logic [SH_W-1:0]      a_cnt, b_cnt, shift_sum, cnt;
  logic                 a_msb, b_msb;
  logic [2*TRUNC_W-1:0] prod;

  approx_norm_lane #(
    .IN_W    (IN_W),
    .TRUNC_W (TRUNC_W),
    .CNT_W   (SH_W)
  ) u_lane_a (
    .clk      (clk),
    .rst      (rst),
    .load     (lane_load),
    .step     (lane_step),
    .data     (a),
    .norm_top (a_top),
    .count    (a_cnt),
    .msb_set  (a_msb)
  );

  approx_norm_lane #(
    .IN_W    (IN_W),
    .TRUNC_W (TRUNC_W),
    .CNT_W   (SH_W)
  ) u_lane_b (
    .clk      (clk),
    .rst      (rst),
    .load     (lane_load),
    .step     (lane_step),
    .data     (b),
    .norm_top (b_top),
    .count    (b_cnt),
    .msb_set  (b_msb)
  );

  assign zero_op   = (a == '0) || (b == '0);
  assign shift_sum = a_cnt + b_cnt;
  assign prod      = {{TRUNC_W{1'b0}}, a_top} * {{TRUNC_W{1'b0}}, b_top};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = zero_op ? DONE : NORM;
      NORM:    if (a_msb && b_msb) state_next = MULT;
      MULT:    state_next = (shift_sum == '0) ? DONE : DENORM;
      DENORM:  if (cnt == SH_W'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    lane_load = (state == IDLE) && start;
    lane_step = (state == NORM);
  end

  // Result is placed at the top of the output word, then shifted down by sa+sb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      shift_total <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result      <= '0;
            shift_total <= '0;
            cnt         <= '0;
          end
        end
        MULT: begin
          result      <= OUT_W'(prod) << (OUT_W - 2 * TRUNC_W);
          shift_total <= shift_sum;
          cnt         <= shift_sum;
        end
        DENORM: begin
          result <= result >> 1;
          cnt    <= cnt - SH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_engine.sv
// Self-checking bench for approx_mult_engine (default IN_W=16, TRUNC_W=8).
// Honours APPROX_MULT_ROUND_EN in its reference model.
module tb_approx_mult_engine;

  localparam int IN_W    = 16;
  localparam int TRUNC_W = 8;
  localparam int OUT_W   = 2 * IN_W;
  localparam int SH_W    = $clog2(2 * IN_W) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IN_W-1:0]  a, b;
  logic             in_ready, out_valid, out_ready;
  logic [OUT_W-1:0] result;
  logic [SH_W-1:0]  shift_total;

  int n_checks = 0;
  int n_fail   = 0;

  approx_mult_engine #(
    .IN_W    (IN_W),
    .TRUNC_W (TRUNC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .shift_total (shift_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: leading-zero count from the operand magnitude, plain integer arithmetic.
  function automatic void model(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y,
                                output longint r, output int st, output int lat);
    int sx, sy;
    longint xn, yn, tx, ty;
    if (x == 0 || y == 0) begin
      r = 0; st = 0; lat = 1;
      return;
    end
    sx = IN_W - $clog2(int'(x) + 1);
    sy = IN_W - $clog2(int'(y) + 1);
    xn = longint'(x) * (longint'(1) << sx);
    yn = longint'(y) * (longint'(1) << sy);
    tx = xn / (longint'(1) << (IN_W - TRUNC_W));
    ty = yn / (longint'(1) << (IN_W - TRUNC_W));
`ifdef APPROX_MULT_ROUND_EN
    if (TRUNC_W < IN_W) begin
      if (((xn >> (IN_W - TRUNC_W - 1)) % 2 == 1) && tx < (longint'(1) << TRUNC_W) - 1) tx++;
      if (((yn >> (IN_W - TRUNC_W - 1)) % 2 == 1) && ty < (longint'(1) << TRUNC_W) - 1) ty++;
    end
`endif
    r   = ((tx * ty) * (longint'(1) << (OUT_W - 2 * TRUNC_W))) / (longint'(1) << (sx + sy));
    st  = sx + sy;
    lat = ((sx > sy) ? sx : sy) + sx + sy + 3;
  endfunction

  // Called at #1 after an edge with the engine idle; returns at #1 after out_valid rises.
  task automatic do_op(input logic [IN_W-1:0] ai, input logic [IN_W-1:0] bi,
                       output logic [OUT_W-1:0] r, output logic [SH_W-1:0] st, output int lat);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = result;
    st = shift_total;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic run_and_check(input logic [IN_W-1:0] ai, input logic [IN_W-1:0] bi, input int hold);
    longint er;
    int est, elat, lat;
    logic [OUT_W-1:0] r;
    logic [SH_W-1:0] st;
    model(ai, bi, er, est, elat);
    do_op(ai, bi, r, st, lat);
    check($sformatf("result %h*%h", ai, bi), 64'(r), 64'(er));
    check($sformatf("shift_total %h*%h", ai, bi), 64'(st), 64'(est));
    check($sformatf("latency %h*%h", ai, bi), 64'(lat), 64'(elat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'(er));
    end
    release_out();
  endtask

  initial begin
    logic [IN_W-1:0]  ra, rb;
    logic [OUT_W-1:0] r;
    logic [SH_W-1:0]  st;
    int lat;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_shift_total", 64'(shift_total), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations.
    do_op(16'h0003, 16'h0005, r, st, lat);
    check("c1_result", 64'(r), 64'h0000_000F);
    check("c1_shift_total", 64'(st), 64'd27);
    check("c1_latency", 64'(lat), 64'd44);
    release_out();

    do_op(16'h8000, 16'h8000, r, st, lat);
    check("c2_result", 64'(r), 64'h4000_0000);
    check("c2_shift_total", 64'(st), 64'd0);
    check("c2_latency", 64'(lat), 64'd3);
    release_out();

    do_op(16'hFFFF, 16'hFFFF, r, st, lat);
    check("c3_result", 64'(r), 64'hFE01_0000);
    release_out();

    do_op(16'h80C0, 16'h8000, r, st, lat);
`ifdef APPROX_MULT_ROUND_EN
    check("c4_result", 64'(r), 64'h4080_0000);
`else
    check("c4_result", 64'(r), 64'h4000_0000);
`endif
    release_out();

    // Zero operand: one-cycle latency, output held while start pulses are ignored.
    do_op(16'h0000, 16'h1234, r, st, lat);
    check("zero_latency", 64'(lat), 64'd1);
    check("zero_result", 64'(r), 64'd0);
    check("zero_shift_total", 64'(st), 64'd0);
    for (int i = 0; i < 5; i++) begin
      a = 16'h00F1; b = 16'h0033; start = (i % 2 == 0);
      @(posedge clk); #1;
      check("zero_hold_valid", 64'(out_valid), 64'd1);
      check("zero_hold_result", 64'(result), 64'd0);
      check("zero_hold_in_ready", 64'(in_ready), 64'd0);
    end
    start = 1'b0;
    release_out();
    @(posedge clk); #1;
    check("no_queued_op", 64'(out_valid), 64'd0);

    // Randomised operands with varied magnitudes and consumer back-pressure.
    for (int k = 0; k < 24; k++) begin
      ra = IN_W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      rb = IN_W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if (k % 8 == 7) ra = '0;
      run_and_check(ra, rb, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of DENORM, then a clean operation.
    a = 16'h0003; b = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_and_check(16'h8000, 16'h8000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
